// File: rtl/warp_pc_scheduler.sv
// Per-warp instruction address owner and round-robin fetch arbiter for the SM core.
// One offer register feeds the fetch port; retirements update PCs and re-ready warps.
module warp_pc_scheduler #(
    parameter int unsigned NUM_WARPS = 4,
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned WID_W     = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    output logic              fetch_valid,
    output logic [WID_W-1:0]  fetch_warp,
    output logic [ADDR_W-1:0] fetch_addr,
    input  logic              fetch_ready,
    input  logic              done_valid,
    input  logic [WID_W-1:0]  done_warp,
    input  logic              done_branch,
    input  logic [ADDR_W-1:0] done_target,
    input  logic              done_halt,
    output logic              busy,
    output logic              kernel_done
);

    typedef enum logic [1:0] {W_IDLE, W_READY, W_WAIT, W_HALTED} warp_state_e;
    typedef enum logic {G_IDLE, G_RUN} glob_state_e;

    glob_state_e       g_q, g_d;
    warp_state_e       ws_q [NUM_WARPS];
    warp_state_e       ws_d [NUM_WARPS];
    logic [ADDR_W-1:0] pc_q [NUM_WARPS];
    logic [ADDR_W-1:0] pc_d [NUM_WARPS];
    logic [WID_W-1:0]  rr_q, rr_d;
    logic              fetch_valid_q, fetch_valid_d;
    logic [WID_W-1:0]  fetch_warp_q, fetch_warp_d;
    logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
    logic              busy_q, busy_d;
    logic              kernel_done_q, kernel_done_d;

    logic              accept, arb_en, found, all_halted;
    logic [WID_W-1:0]  search_base, cand, idx;

    always_comb begin
        g_d           = g_q;
        ws_d          = ws_q;
        pc_d          = pc_q;
        rr_d          = rr_q;
        fetch_valid_d = fetch_valid_q;
        fetch_warp_d  = fetch_warp_q;
        fetch_addr_d  = fetch_addr_q;
        kernel_done_d = 1'b0;
        accept        = fetch_valid_q && fetch_ready;
        arb_en        = !fetch_valid_q || fetch_ready;
        found         = 1'b0;
        all_halted    = 1'b1;
        search_base   = rr_q;
        cand          = '0;
        idx           = '0;

        case (g_q)
            G_IDLE: begin
                fetch_valid_d = 1'b0;
                if (start) begin
                    g_d  = G_RUN;
                    rr_d = WID_W'(NUM_WARPS - 1);
                    for (int unsigned w = 0; w < NUM_WARPS; w++) begin
                        ws_d[w] = W_READY;
                        pc_d[w] = start_addr;
                    end
                end
            end
            default: begin
                if (done_valid && ws_q[done_warp] == W_WAIT) begin
                    if (done_halt) begin
                        ws_d[done_warp] = W_HALTED;
                    end else begin
                        pc_d[done_warp] = done_branch ? done_target
                                                      : pc_q[done_warp] + ADDR_W'(1);
                        ws_d[done_warp] = W_READY;
                    end
                end
                // Search uses pre-edge states so warps readied on this edge wait a cycle.
                if (arb_en) begin
                    if (accept) begin
                        ws_d[fetch_warp_q] = W_WAIT;
                        rr_d               = fetch_warp_q;
                        search_base        = fetch_warp_q;
                    end
                    for (int unsigned i = 1; i <= NUM_WARPS; i++) begin
                        idx = search_base + WID_W'(i);
                        if (!found && ws_q[idx] == W_READY && !(accept && idx == fetch_warp_q)) begin
                            found = 1'b1;
                            cand  = idx;
                        end
                    end
                    fetch_valid_d = found;
                    if (found) begin
                        fetch_warp_d = cand;
                        fetch_addr_d = pc_q[cand];
                    end
                end
                for (int unsigned w = 0; w < NUM_WARPS; w++) begin
                    if (ws_d[w] != W_HALTED) all_halted = 1'b0;
                end
                if (all_halted) begin
                    g_d           = G_IDLE;
                    fetch_valid_d = 1'b0;
                    kernel_done_d = 1'b1;
                end
            end
        endcase
        busy_d = (g_d == G_RUN);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            g_q           <= G_IDLE;
            rr_q          <= WID_W'(NUM_WARPS - 1);
            fetch_valid_q <= 1'b0;
            fetch_warp_q  <= '0;
            fetch_addr_q  <= '0;
            busy_q        <= 1'b0;
            kernel_done_q <= 1'b0;
            for (int unsigned w = 0; w < NUM_WARPS; w++) begin
                ws_q[w] <= W_IDLE;
                pc_q[w] <= '0;
            end
        end else begin
            g_q           <= g_d;
            rr_q          <= rr_d;
            fetch_valid_q <= fetch_valid_d;
            fetch_warp_q  <= fetch_warp_d;
            fetch_addr_q  <= fetch_addr_d;
            busy_q        <= busy_d;
            kernel_done_q <= kernel_done_d;
            ws_q          <= ws_d;
            pc_q          <= pc_d;
        end
    end

    assign fetch_valid = fetch_valid_q;
    assign fetch_warp  = fetch_warp_q;
    assign fetch_addr  = fetch_addr_q;
    assign busy        = busy_q;
    assign kernel_done = kernel_done_q;

endmodule

// File: tb/tb_warp_pc_scheduler.sv
// Scoreboard bench for warp_pc_scheduler: directed scenarios plus randomized traffic
// checked against a transaction-level model of warps, PCs and round-robin order.
module tb_warp_pc_scheduler;

    localparam int NW = 4;
    localparam int AW = 16;
    localparam int WW = 2;
    localparam int ST_IDLE = 0, ST_READY = 1, ST_WAIT = 2, ST_HALT = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] start_addr = '0;
    logic          fetch_valid;
    logic [WW-1:0] fetch_warp;
    logic [AW-1:0] fetch_addr;
    logic          fetch_ready = 1'b0;
    logic          done_valid = 1'b0;
    logic [WW-1:0] done_warp = '0;
    logic          done_branch = 1'b0;
    logic [AW-1:0] done_target = '0;
    logic          done_halt = 1'b0;
    logic          busy;
    logic          kernel_done;

    warp_pc_scheduler #(.NUM_WARPS(NW), .ADDR_W(AW), .WID_W(WW)) dut (
        .clk(clk), .reset(reset), .start(start), .start_addr(start_addr),
        .fetch_valid(fetch_valid), .fetch_warp(fetch_warp), .fetch_addr(fetch_addr),
        .fetch_ready(fetch_ready), .done_valid(done_valid), .done_warp(done_warp),
        .done_branch(done_branch), .done_target(done_target), .done_halt(done_halt),
        .busy(busy), .kernel_done(kernel_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: warp status and PC per warp, last-granted warp, current offer.
    int m_st [NW];
    int m_pc [NW];
    int m_last;
    bit m_run, m_fv, m_kd;
    int m_fw, m_fa;

    logic [WW+AW-1:0] exp_q [$];
    logic [WW+AW-1:0] acc_log [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int w = 0; w < NW; w++) begin
            m_st[w] = ST_IDLE;
            m_pc[w] = 0;
        end
        m_last = NW - 1;
        m_run = 0; m_fv = 0; m_kd = 0; m_fw = 0; m_fa = 0;
    endfunction

    function automatic void model_step();
        int  nst [NW];
        bit  halted_all;
        m_kd = 0;
        if (!m_run) begin
            m_fv = 0;
            if (start) begin
                m_run  = 1;
                m_last = NW - 1;
                for (int w = 0; w < NW; w++) begin
                    m_st[w] = ST_READY;
                    m_pc[w] = int'(start_addr);
                end
            end
            return;
        end
        nst = m_st;
        if (done_valid && m_st[done_warp] == ST_WAIT) begin
            if (done_halt) nst[done_warp] = ST_HALT;
            else begin
                m_pc[done_warp] = done_branch ? int'(done_target) : (m_pc[done_warp] + 1) % 65536;
                nst[done_warp] = ST_READY;
            end
        end
        if (!m_fv || fetch_ready) begin
            bit granted = m_fv;
            int gw = m_fw;
            if (granted) begin
                nst[gw] = ST_WAIT;
                m_last = gw;
            end
            m_fv = 0;
            for (int k = 1; k <= NW; k++) begin
                int w = (m_last + k) % NW;
                if (!m_fv && m_st[w] == ST_READY && !(granted && w == gw)) begin
                    m_fv = 1; m_fw = w; m_fa = m_pc[w];
                end
            end
        end
        m_st = nst;
        halted_all = 1;
        for (int w = 0; w < NW; w++) if (m_st[w] != ST_HALT) halted_all = 0;
        if (halted_all) begin
            m_run = 0; m_fv = 0; m_kd = 1;
        end
    endfunction

    task automatic tick();
        if (!reset && m_fv && fetch_ready) exp_q.push_back({WW'(m_fw), AW'(m_fa)});
        @(posedge clk);
        if (!reset) model_step();
        #1;
    endtask

    // Monitor: sample mid-cycle, pop expected grant whenever the DUT's offer is taken.
    always @(negedge clk) begin
        logic [WW+AW-1:0] e;
        chk("fetch_valid", 32'(fetch_valid), 32'(m_fv));
        chk("busy", 32'(busy), 32'(m_run));
        chk("kernel_done", 32'(kernel_done), 32'(m_kd));
        if (fetch_valid && m_fv) begin
            chk("offer_warp", 32'(fetch_warp), 32'(m_fw));
            chk("offer_addr", 32'(fetch_addr), 32'(m_fa));
        end
        if (fetch_valid && fetch_ready) begin
            acc_log.push_back({fetch_warp, fetch_addr});
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL accept_unexpected actual=w%0d@0x%0h expected=none", fetch_warp, fetch_addr);
            end else begin
                e = exp_q.pop_front();
                chk("accept_tuple", 32'({fetch_warp, fetch_addr}), 32'(e));
            end
        end
    end

    task automatic chk_log(input int i, input int w, input int a);
        if (i >= acc_log.size()) begin
            checks++; errors++;
            $display("FAIL accept_log_missing actual=%0d entries expected>%0d", acc_log.size(), i);
        end else chk("accept_order", 32'(acc_log[i]), 32'({WW'(w), AW'(a)}));
    endtask

    task automatic chk_outputs_zero();
        chk("rst_fetch_valid", 32'(fetch_valid), 0);
        chk("rst_fetch_warp", 32'(fetch_warp), 0);
        chk("rst_fetch_addr", 32'(fetch_addr), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_kernel_done", 32'(kernel_done), 0);
    endtask

    task automatic do_reset();
        done_valid = 0;
        #1;
        reset = 1;
        model_reset();
        exp_q.delete();
        #1;
        chk_outputs_zero();
        start = 1;
        start_addr = 16'h0777;
        tick();
        tick();
        reset = 0;
        start = 0;
    endtask

    task automatic retire(input int w, input bit h, input bit b, input int tgt);
        int n = 0;
        while (m_st[w] != ST_WAIT && n < 40) begin
            tick();
            n++;
        end
        if (m_st[w] != ST_WAIT) begin
            checks++; errors++;
            $display("FAIL retire_wait_timeout actual=state%0d expected=in-flight w%0d", m_st[w], w);
        end
        done_valid = 1; done_warp = WW'(w); done_halt = h; done_branch = b; done_target = AW'(tgt);
        tick();
        done_valid = 0; done_halt = 0; done_branch = 0;
    endtask

    task automatic launch(input int addr);
        start = 1; start_addr = AW'(addr);
        tick();
        start = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        model_reset();
        tick(); tick();
        chk_outputs_zero();
        reset = 0;

        // Launch and four back-to-back grants
        fetch_ready = 1;
        acc_log.delete();
        launch(16'h0010);
        repeat (6) tick();
        for (int i = 0; i < 4; i++) chk_log(i, i, 16'h0010);

        // Branch and plain retire
        acc_log.delete();
        retire(2, 0, 1, 16'h0100);
        retire(1, 0, 0, 0);
        repeat (4) tick();
        chk_log(0, 2, 16'h0100);
        chk_log(1, 1, 16'h0011);

        // Stall with retirements, then release
        fetch_ready = 0;
        retire(3, 0, 0, 0);
        retire(0, 0, 0, 0);
        retire(2, 0, 0, 0);
        repeat (3) tick();
        chk("stall_valid", 32'(fetch_valid), 1);
        chk("stall_warp", 32'(fetch_warp), 3);
        chk("stall_addr", 32'(fetch_addr), 16'h0011);
        acc_log.delete();
        fetch_ready = 1;
        repeat (5) tick();
        chk_log(0, 3, 16'h0011);
        chk_log(1, 0, 16'h0011);
        chk_log(2, 2, 16'h0101);

        // Mid-run reset aborts
        do_reset();
        tick();

        // Address wrap and ignored retire of a non-waiting warp
        acc_log.delete();
        launch(16'hFFFF);
        done_valid = 1; done_warp = 2'd3; done_target = 16'h1234; done_branch = 1;
        tick();
        done_valid = 0; done_branch = 0;
        repeat (5) tick();
        retire(0, 0, 0, 0);
        repeat (3) tick();
        chk_log(3, 3, 16'hFFFF);
        chk_log(4, 0, 16'h0000);

        // Halt every warp, then relaunch
        retire(0, 1, 1, 16'h0AAA);
        retire(1, 1, 0, 0);
        retire(2, 1, 0, 0);
        retire(3, 1, 0, 0);
        chk("halt_kernel_done", 32'(kernel_done), 1);
        chk("halt_busy", 32'(busy), 0);
        chk("halt_fetch_valid", 32'(fetch_valid), 0);
        tick();
        chk("halt_pulse_end", 32'(kernel_done), 0);
        acc_log.delete();
        launch(16'h0200);
        repeat (3) tick();
        chk("relaunch_busy", 32'(busy), 1);
        chk_log(0, 0, 16'h0200);

        // Randomized traffic
        for (int c = 0; c < 2000; c++) begin
            int r;
            int pick [$];
            fetch_ready = ($urandom_range(0, 3) != 0);
            if (!m_run && $urandom_range(0, 4) == 0) begin
                start = 1;
                start_addr = ($urandom_range(0, 3) == 0) ? AW'(16'hFFFC + $urandom_range(0, 3))
                                                         : AW'($urandom);
            end else start = 0;
            done_valid = 0; done_halt = 0; done_branch = 0;
            r = $urandom_range(0, 9);
            pick.delete();
            for (int w = 0; w < NW; w++) if (m_st[w] == ST_WAIT) pick.push_back(w);
            if (r < 6 && pick.size() > 0) begin
                done_valid  = 1;
                done_warp   = WW'(pick[$urandom_range(0, pick.size() - 1)]);
                done_halt   = ($urandom_range(0, 15) == 0);
                done_branch = ($urandom_range(0, 2) == 0);
                done_target = AW'($urandom);
            end else if (r == 6) begin
                done_valid  = 1;
                done_warp   = WW'($urandom_range(0, NW - 1));
                done_halt   = $urandom_range(0, 1) == 1;
                done_branch = $urandom_range(0, 1) == 1;
                done_target = AW'($urandom);
            end
            if ($urandom_range(0, 599) == 0) do_reset();
            else tick();
        end
        start = 0; done_valid = 0; fetch_ready = 1;
        repeat (4) tick();
        chk("queue_drained", 32'(exp_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
